nn_result_display: RTL and testbench
====================================

Name: nn_result_display

Overview:
- Parametrised successor to the single-digit argmax seven-segment decoder in the FPGA top level.
- Captures each forward-pass result (class and score) into a small history ring buffer and drives NUM_DIGITS active-low seven-segment digits.
- Supports four display modes, scrolling through past results, and a timed blink announcing each new result.
- Sits between the neural_network done/argmax outputs and the HEX pins.

Parameters:
- NUM_DIGITS, 4, number of seven-segment digits driven (1..6)
- CLASS_W, 4, width of the result class index
- SCORE_W, 16, width of the result score; must be ≤ 4*NUM_DIGITS
- NUM_CLASSES, 10, classes ≥ this value are invalid and shown as dash
- HIST_DEPTH, 4, results held in history (power of 2, ≥ 2)
- PHASE_CYCLES, 12_500_000, clk cycles per blink phase (≥ 1)
- BLINK_FLASHES, 3, dark/lit pairs after each capture (0 disables blink)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- result_valid  in  1  one-cycle pulse: result_class/result_score valid (driven from done)
- result_class  in  CLASS_W  argmax class index
- result_score  in  SCORE_W  winning logit/score, unsigned raw bits
- mode  in  2  0=class, 1=score hex, 2=history classes, 3=all blank
- scroll  in  1  one-cycle pulse: advance viewed history entry
- hex_out  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], active-low, digit 0 rightmost
- led_new  out  1  high while the post-capture blink sequence runs
- hist_count  out  $clog2(HIST_DEPTH+1)  number of valid history entries

Behaviour:
- Reset (async, resetn=0):
  - hex_out = all ones (blank).
  - led_new = 0, hist_count = 0, write pointer = 0, view index = 0.
  - Blink idle; history contents don't-care.
- Capture (rising edge with result_valid=1):
  - Write {class, score} at wr_ptr; wr_ptr increments modulo HIST_DEPTH.
  - hist_count increments, saturating at HIST_DEPTH.
  - view index forced to 0.
- View index:
  - 0 = newest, k = k-th older entry.
  - scroll without result_valid: view = (view+1) mod hist_count; no effect when hist_count ≤ 1.
  - scroll and result_valid in the same cycle: capture wins, scroll is ignored.
- Display content, computed from the selected entry:
  - mode 0: digit 0 shows the class glyph; other digits blank.
  - mode 1: score in hex; nibble i on digit i (0-F glyphs); digits beyond ceil(SCORE_W/4) blank; upper partial nibble zero-extended.
  - mode 2: digit i shows the class of the i-th newest entry (ignores view); digits with i ≥ hist_count blank.
  - mode 3: all blank.
- Class glyphs:
  - 0-9 standard, same patterns as the existing decoder: 0=1000000 … 9=0010000.
  - class ≥ NUM_CLASSES shows dash 0111111.
  - hist_count = 0 in modes 0/1 shows all blank.
- Latency:
  - hex_out is registered.
  - A change in state or in mode appears on hex_out one clk edge after the state register or mode input changes.
  - A captured result therefore appears 2 edges after result_valid is sampled.
- Blink FSM, states IDLE, DARK, LIT:
  - Capture → DARK, phase_cnt = PHASE_CYCLES-1, toggles_left = 2*BLINK_FLASHES-1. Capture while blinking restarts the sequence.
  - Each cycle in DARK/LIT: phase_cnt decrements.
  - At phase_cnt = 0: if toggles_left = 0 go to IDLE; else flip DARK↔LIT, decrement toggles_left, reload phase_cnt.
  - DARK forces all digits blank regardless of mode.
  - led_new = 1 in DARK or LIT (registered with hex_out).
  - BLINK_FLASHES = 0: captures never leave IDLE.
- Reset mid-blink or mid-capture: everything returns to reset values immediately; no partial write survives (hist_count = 0).
- Width rules:
  - Counters use $clog2 sizing.
  - phase_cnt sized $clog2(PHASE_CYCLES).
  - No arithmetic on score; pure nibble slicing.

Decomposition:
- Package nn_display_pkg holds:
  - SEG_BLANK (7'h7F) and SEG_DASH (7'h3F).
  - 16-entry hex glyph constant table.
  - Mode encodings MODE_CLASS/MODE_SCORE/MODE_HIST/MODE_OFF.
  - Blink state encodings.
- One sub-module, seg7_glyph: combinational 4-bit nibble plus is_class/limit inputs → 7-bit glyph, instantiated per digit.
- History RAM is an inferred register array inside nn_result_display.

Test Plan:
- Reset: resetn=0 mid-operation → hex_out=all ones, led_new=0, hist_count=0 within the same cycle (async), held until release.
- Capture, mode 0 (PHASE_CYCLES=4, BLINK_FLASHES=2): pulse result_valid with class=7, score=16'h1A3F.
  - led_new rises 2 edges later; digit 0 dark 4 cycles, lit 4, dark 4, lit 4; then led_new=0.
  - Steady state: digit 0 shows 1111000, digits 1-3 blank.
- Mode 1: same entry → digits 3..0 show 1,A,3,F glyphs (1111001, 0001000, 0110000, 0001110) one edge after mode changes.
- History wrap (HIST_DEPTH=4): capture classes 1,2,3,4,5 in mode 2.
  - Digits 0..3 show 5,4,3,2; hist_count=4.
  - Class 12 captured next → digit 0 shows dash.
- Scroll: after captures of 3, then 8, scroll once in mode 0 → digit 0 shows 3; scroll again → 8 (wraps).
  - scroll coincident with result_valid(class 6) → digit 0 shows 6, view=0.
- Blink restart and disable: second capture during LIT restarts DARK with a full 4*PHASE_CYCLES sequence.
  - BLINK_FLASHES=0 build: led_new never asserts.

Source files
------------

// File: rtl/nn_display_pkg.sv
// Shared constants for the result display: segment glyphs, display modes and
// blink sequencer states. Segments are active-low, ordered {g,f,e,d,c,b,a}.
package nn_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry n holds the glyph for hex digit n (index 0 is the rightmost slot).
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    MODE_CLASS = 2'd0,
    MODE_SCORE = 2'd1,
    MODE_HIST  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    BLINK_IDLE = 2'd0,
    BLINK_DARK = 2'd1,
    BLINK_LIT  = 2'd2
  } blink_e;

endpackage

// File: rtl/seg7_glyph.sv
// One seven-segment digit: hex glyph for a nibble, dash for an out-of-range
// class index, or blank.
module seg7_glyph
  import nn_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       is_class,
  input  logic [4:0] limit,
  input  logic       blank,
  output logic [6:0] glyph
);

  always_comb begin
    if (blank) begin
      glyph = SEG_BLANK;
    end else if (is_class && ({1'b0, nibble} >= limit)) begin
      glyph = SEG_DASH;
    end else begin
      glyph = HEX_GLYPH[nibble];
    end
  end

endmodule

// File: rtl/nn_result_display.sv
// Captures network results into a history ring and drives NUM_DIGITS
// active-low seven-segment digits, with scrolling and a post-capture blink.
module nn_result_display
  import nn_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLASS_W       = 4,
  parameter int SCORE_W       = 16,
  parameter int NUM_CLASSES   = 10,
  parameter int HIST_DEPTH    = 4,
  parameter int PHASE_CYCLES  = 12_500_000,
  parameter int BLINK_FLASHES = 3
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            result_valid,
  input  logic [CLASS_W-1:0]              result_class,
  input  logic [SCORE_W-1:0]              result_score,
  input  logic [1:0]                      mode,
  input  logic                            scroll,
  output logic [7*NUM_DIGITS-1:0]         hex_out,
  output logic                            led_new,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

  localparam int PTR_W        = $clog2(HIST_DEPTH);
  localparam int CNT_W        = $clog2(HIST_DEPTH + 1);
  localparam int PH_W         = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int TG_W         = (BLINK_FLASHES > 0) ? $clog2(2 * BLINK_FLASHES) : 1;
  localparam int SCORE_DIGITS = (SCORE_W + 3) / 4;
  localparam logic       BLINK_EN    = (BLINK_FLASHES > 0);
  localparam logic [4:0] CLASS_LIMIT = (NUM_CLASSES >= 16) ? 5'd16 : 5'(NUM_CLASSES);
  localparam logic [PH_W-1:0] PHASE_LOAD = PH_W'(PHASE_CYCLES - 1);
  localparam logic [TG_W-1:0] TOG_LOAD   = (BLINK_FLASHES > 0) ? TG_W'(2 * BLINK_FLASHES - 1) : '0;

  logic [CLASS_W-1:0] hist_class [HIST_DEPTH];
  logic [SCORE_W-1:0] hist_score [HIST_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   view;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   view_inc;

  blink_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [TG_W-1:0] tog_q, tog_d;

  logic [3:0] nib    [NUM_DIGITS];
  logic       is_cls [NUM_DIGITS];
  logic [4:0] lim    [NUM_DIGITS];
  logic       blk    [NUM_DIGITS];
  logic [6:0] glyph_p0 [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_p0;

  function automatic logic [3:0] class_nib(input logic [CLASS_W-1:0] c);
    logic [CLASS_W+3:0] w;
    w = {4'b0000, c};
    return w[3:0];
  endfunction

  // Any class bits above the nibble push the digit to the dash glyph.
  function automatic logic [4:0] class_limit(input logic [CLASS_W-1:0] c);
    logic [CLASS_W+3:0] w;
    w = {4'b0000, c};
    return (w[CLASS_W+3:4] != '0) ? 5'd0 : CLASS_LIMIT;
  endfunction

  assign hist_count = count_q;
  assign view_inc   = CNT_W'(view) + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (result_valid) begin
      hist_class[wr_ptr] <= result_class;
      hist_score[wr_ptr] <= result_score;
    end
  end

  // Capture outranks scroll and always snaps the view back to the newest entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      view    <= '0;
      count_q <= '0;
    end else if (result_valid) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      view   <= '0;
      if (count_q != CNT_W'(HIST_DEPTH)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end else if (scroll && (count_q > CNT_W'(1))) begin
      view <= (view_inc >= count_q) ? '0 : PTR_W'(view_inc);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BLINK_IDLE;
      phase_q <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tog_d   = tog_q;
    if (state_q == BLINK_DARK || state_q == BLINK_LIT) begin
      if (phase_q == '0) begin
        if (tog_q == '0) begin
          state_d = BLINK_IDLE;
        end else begin
          state_d = (state_q == BLINK_DARK) ? BLINK_LIT : BLINK_DARK;
          tog_d   = tog_q - TG_W'(1);
          phase_d = PHASE_LOAD;
        end
      end else begin
        phase_d = phase_q - PH_W'(1);
      end
    end
    if (result_valid && BLINK_EN) begin
      state_d = BLINK_DARK;
      phase_d = PHASE_LOAD;
      tog_d   = TOG_LOAD;
    end
  end

  // Stage p0: per-digit glyph selection from current state and mode.
  always_comb begin
    logic [PTR_W-1:0]        sel_idx;
    logic [PTR_W-1:0]        idx;
    logic [CLASS_W-1:0]      sel_class;
    logic [4*NUM_DIGITS-1:0] score_ext;
    sel_idx   = wr_ptr - PTR_W'(1) - view;
    idx       = '0;
    sel_class = hist_class[sel_idx];
    score_ext = '0;
    score_ext[SCORE_W-1:0] = hist_score[sel_idx];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i]    = '0;
      is_cls[i] = 1'b0;
      lim[i]    = 5'd16;
      blk[i]    = 1'b1;
    end
    if (state_q != BLINK_DARK) begin
      case (mode_e'(mode))
        MODE_CLASS: begin
          if (count_q != '0) begin
            nib[0]    = class_nib(sel_class);
            is_cls[0] = 1'b1;
            lim[0]    = class_limit(sel_class);
            blk[0]    = 1'b0;
          end
        end
        MODE_SCORE: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = score_ext[4*i +: 4];
            blk[i] = (count_q == '0) || (i >= SCORE_DIGITS);
          end
        end
        MODE_HIST: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i < int'(count_q)) begin
              idx       = wr_ptr - PTR_W'(1) - PTR_W'(i);
              nib[i]    = class_nib(hist_class[idx]);
              is_cls[i] = 1'b1;
              lim[i]    = class_limit(hist_class[idx]);
              blk[i]    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph u_glyph (
      .nibble   (nib[g]),
      .is_class (is_cls[g]),
      .limit    (lim[g]),
      .blank    (blk[g]),
      .glyph    (glyph_p0[g])
    );
  end

  always_comb begin
    hex_p0 = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_p0[7*i +: 7] = glyph_p0[i];
    end
  end

  // Stage p1: registered digit drive and new-result indicator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_out <= '1;
      led_new <= 1'b0;
    end else begin
      hex_out <= hex_p0;
      led_new <= (state_q != BLINK_IDLE);
    end
  end

endmodule

// File: tb/tb_nn_result_display.sv
// Directed bench for nn_result_display: table of display vectors on a
// no-blink build plus hand sequences for blink timing and async reset.
module tb_nn_result_display;

  localparam logic [6:0] B = 7'h7F;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        result_valid = 1'b0;
  logic [3:0]  result_class = '0;
  logic [15:0] result_score = '0;
  logic [1:0]  mode = 2'd0;
  logic        scroll = 1'b0;
  logic [27:0] hex_b, hex_n;
  logic        led_b, led_n;
  logic [2:0]  cnt_b, cnt_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_result_display #(
    .NUM_DIGITS(4), .CLASS_W(4), .SCORE_W(16), .NUM_CLASSES(10),
    .HIST_DEPTH(4), .PHASE_CYCLES(4), .BLINK_FLASHES(2)
  ) u_blink (
    .clk(clk), .resetn(resetn), .result_valid(result_valid),
    .result_class(result_class), .result_score(result_score),
    .mode(mode), .scroll(scroll), .hex_out(hex_b), .led_new(led_b),
    .hist_count(cnt_b)
  );

  nn_result_display #(
    .NUM_DIGITS(4), .CLASS_W(4), .SCORE_W(16), .NUM_CLASSES(10),
    .HIST_DEPTH(4), .PHASE_CYCLES(4), .BLINK_FLASHES(0)
  ) u_noblink (
    .clk(clk), .resetn(resetn), .result_valid(result_valid),
    .result_class(result_class), .result_score(result_score),
    .mode(mode), .scroll(scroll), .hex_out(hex_n), .led_new(led_n),
    .hist_count(cnt_n)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        valid;
    logic [3:0]  cls;
    logic [15:0] score;
    logic        scroll;
    logic [27:0] exp_hex;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [26];

  function automatic logic [27:0] h4(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
  endtask

  task automatic capture(input logic [3:0] c, input logic [15:0] s);
    result_class = c;
    result_score = s;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  // Called right after the capture edge; checks the 16 dark/lit samples
  // and the return to idle.
  task automatic blink_check(input string tag, input logic [6:0] g);
    logic [27:0] exp;
    for (int j = 0; j < 16; j++) begin
      step();
      exp = (((j / 4) % 2) == 0) ? h4(B, B, B, B) : h4(B, B, B, g);
      chk($sformatf("%s_led_%0d", tag, j), {31'd0, led_b}, 32'd1);
      chk($sformatf("%s_hex_%0d", tag, j), {4'd0, hex_b}, {4'd0, exp});
    end
    step();
    chk($sformatf("%s_led_end", tag), {31'd0, led_b}, 32'd0);
    chk($sformatf("%s_hex_end", tag), {4'd0, hex_b}, {4'd0, h4(B, B, B, g)});
  endtask

  initial begin
    // rst mode valid cls score scroll exp_hex exp_cnt
    vecs[0]  = '{1, 2'd0, 0, 4'd0,  16'h0000, 0, h4(B, B, B, B), 3'd0};
    vecs[1]  = '{0, 2'd0, 1, 4'd7,  16'h1A3F, 0, h4(B, B, B, 7'h78), 3'd1};
    vecs[2]  = '{0, 2'd1, 0, 4'd0,  16'h0000, 0, h4(7'h79, 7'h08, 7'h30, 7'h0E), 3'd1};
    vecs[3]  = '{0, 2'd3, 0, 4'd0,  16'h0000, 0, h4(B, B, B, B), 3'd1};
    vecs[4]  = '{0, 2'd2, 1, 4'd1,  16'h0000, 0, h4(B, B, 7'h78, 7'h79), 3'd2};
    vecs[5]  = '{0, 2'd2, 1, 4'd2,  16'h0000, 0, h4(B, 7'h78, 7'h79, 7'h24), 3'd3};
    vecs[6]  = '{0, 2'd2, 1, 4'd3,  16'h0000, 0, h4(7'h78, 7'h79, 7'h24, 7'h30), 3'd4};
    vecs[7]  = '{0, 2'd2, 1, 4'd4,  16'h0000, 0, h4(7'h79, 7'h24, 7'h30, 7'h19), 3'd4};
    vecs[8]  = '{0, 2'd2, 1, 4'd5,  16'h0000, 0, h4(7'h24, 7'h30, 7'h19, 7'h12), 3'd4};
    vecs[9]  = '{0, 2'd2, 1, 4'd12, 16'h0000, 0, h4(7'h30, 7'h19, 7'h12, 7'h3F), 3'd4};
    vecs[10] = '{1, 2'd0, 1, 4'd3,  16'h0000, 0, h4(B, B, B, 7'h30), 3'd1};
    vecs[11] = '{0, 2'd0, 1, 4'd8,  16'hBEEF, 0, h4(B, B, B, 7'h00), 3'd2};
    vecs[12] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h30), 3'd2};
    vecs[13] = '{0, 2'd0, 1, 4'd6,  16'h2C5D, 1, h4(B, B, B, 7'h02), 3'd3};
    vecs[14] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h00), 3'd3};
    vecs[15] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h30), 3'd3};
    vecs[16] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h02), 3'd3};
    vecs[17] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h00), 3'd3};
    vecs[18] = '{0, 2'd1, 0, 4'd0,  16'h0000, 0, h4(7'h03, 7'h06, 7'h06, 7'h0E), 3'd3};
    vecs[19] = '{0, 2'd2, 0, 4'd0,  16'h0000, 0, h4(B, 7'h30, 7'h00, 7'h02), 3'd3};
    vecs[20] = '{0, 2'd1, 0, 4'd0,  16'h0000, 1, h4(7'h40, 7'h40, 7'h40, 7'h40), 3'd3};
    vecs[21] = '{1, 2'd0, 1, 4'd9,  16'h0789, 0, h4(B, B, B, 7'h10), 3'd1};
    vecs[22] = '{0, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, 7'h10), 3'd1};
    vecs[23] = '{0, 2'd1, 0, 4'd0,  16'h0000, 0, h4(7'h40, 7'h78, 7'h00, 7'h10), 3'd1};
    vecs[24] = '{1, 2'd0, 0, 4'd0,  16'h0000, 1, h4(B, B, B, B), 3'd0};
    vecs[25] = '{0, 2'd0, 1, 4'd15, 16'h0000, 0, h4(B, B, B, 7'h3F), 3'd1};

    // Reset state while held.
    step();
    step();
    chk("rst_hex", {4'd0, hex_n}, {4'd0, h4(B, B, B, B)});
    chk("rst_led", {31'd0, led_b}, 32'd0);
    chk("rst_cnt", {29'd0, cnt_b}, 32'd0);
    resetn = 1'b1;
    step();

    for (int v = 0; v < 26; v++) begin
      if (vecs[v].rst) pulse_reset();
      mode         = vecs[v].mode;
      result_class = vecs[v].cls;
      result_score = vecs[v].score;
      result_valid = vecs[v].valid;
      scroll       = vecs[v].scroll;
      step();
      result_valid = 1'b0;
      scroll       = 1'b0;
      step();
      chk($sformatf("vec%0d_hex", v), {4'd0, hex_n}, {4'd0, vecs[v].exp_hex});
      chk($sformatf("vec%0d_cnt", v), {29'd0, cnt_n}, {29'd0, vecs[v].exp_cnt});
      chk($sformatf("vec%0d_noblink_led", v), {31'd0, led_n}, 32'd0);
    end

    // Blink timing after a capture in mode 0.
    pulse_reset();
    mode = 2'd0;
    step();
    capture(4'd7, 16'h1A3F);
    chk("blink_led_lag", {31'd0, led_b}, 32'd0);
    blink_check("blink", 7'h78);
    chk("noblink_led_after", {31'd0, led_n}, 32'd0);

    // Second capture during LIT restarts a full sequence.
    capture(4'd7, 16'h1A3F);
    for (int j = 0; j < 5; j++) step();
    capture(4'd4, 16'h0000);
    blink_check("restart", 7'h19);

    // Asynchronous reset in the middle of a lit phase.
    capture(4'd2, 16'h0000);
    for (int j = 0; j < 6; j++) step();
    chk("pre_reset_led", {31'd0, led_b}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_hex", {4'd0, hex_b}, {4'd0, h4(B, B, B, B)});
    chk("async_led", {31'd0, led_b}, 32'd0);
    chk("async_cnt", {29'd0, cnt_b}, 32'd0);
    step();
    chk("held_hex", {4'd0, hex_b}, {4'd0, h4(B, B, B, B)});
    chk("held_led", {31'd0, led_b}, 32'd0);
    resetn = 1'b1;
    step();
    step();
    chk("post_reset_hex", {4'd0, hex_b}, {4'd0, h4(B, B, B, B)});
    chk("post_reset_cnt", {29'd0, cnt_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
